// File: rtl/drum_mixer.sv
// drum_mixer: N-channel one-shot/looping sample player with a shared ROM port,
// frame-multiplexed fetch, and a saturating mixer feeding the audio codec.
module drum_mixer #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned LOCAL_W    = 14,
  parameter int unsigned SAMPLE_LEN = 16384,
  parameter int unsigned DIV        = 1134,
  parameter int unsigned GAIN_SHIFT = 8,
  parameter int unsigned OUT_W      = 32
) (
  input  logic                                  CLOCK_50,
  input  logic                                  resetn,
  input  logic                                  enable,
  input  logic [CHANNELS-1:0]                   trig,
  input  logic [CHANNELS-1:0]                   loop,
  output logic [$clog2(CHANNELS)+LOCAL_W-1:0]   rom_addr,
  output logic                                  rom_rd,
  input  logic signed [DATA_W-1:0]              rom_q,
  output logic signed [OUT_W-1:0]               sound,
  output logic                                  sound_valid,
  output logic [CHANNELS-1:0]                   active
);

  localparam int unsigned IDX_W  = $clog2(CHANNELS);
  localparam int unsigned SLOT_W = (IDX_W > 0) ? IDX_W : 1;
  localparam int unsigned ADDR_W = IDX_W + LOCAL_W;
  localparam int unsigned ACC_W  = DATA_W + IDX_W;
  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned SH_W   = ACC_W + GAIN_SHIFT;
  localparam int unsigned WIDE   = ((SH_W > OUT_W) ? SH_W : OUT_W) + 1;

  localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [LOCAL_W-1:0] LAST_POS   = LOCAL_W'(SAMPLE_LEN - 1);
  localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, SUM, ADVANCE} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [SLOT_W-1:0]         slot;
  logic [LOCAL_W-1:0]        pos [CHANNELS];
  logic [CHANNELS-1:0]       lat_act;
  logic [CHANNELS-1:0]       issued;
  logic [CHANNELS-1:0]       skip;
  logic                      data_vld;
  logic [SLOT_W-1:0]         data_slot;
  logic signed [ACC_W-1:0]   acc;

  logic                      start_c;
  logic [CHANNELS-1:0]       issue_c;
  logic [SLOT_W-1:0]         issue_idx_c;
  logic signed [ACC_W-1:0]   contrib_c;
  logic signed [ACC_W-1:0]   sum_c;
  logic signed [WIDE-1:0]    wide_c;
  logic signed [OUT_W-1:0]   sat_c;

  // Frame start and which channel (if any) gets its ROM slot issued at this edge
  always_comb begin
    start_c     = enable && (cnt == '0);
    issue_c     = '0;
    issue_idx_c = '0;
    if (state == IDLE && start_c) begin
      issue_c[0] = 1'b1;
    end else if (state == FETCH && slot != LAST_SLOT) begin
      issue_idx_c          = slot + SLOT_W'(1);
      issue_c[issue_idx_c] = 1'b1;
    end
  end

  // Mix path: add the returning sample, apply gain, clamp to the output range
  always_comb begin
    contrib_c = '0;
    if (data_vld && lat_act[data_slot]) contrib_c = ACC_W'(rom_q);
    sum_c  = acc + contrib_c;
    wide_c = WIDE'(sum_c) <<< GAIN_SHIFT;
    if (wide_c > SAT_MAX)      sat_c = OUT_W'(SAT_MAX);
    else if (wide_c < SAT_MIN) sat_c = OUT_W'(SAT_MIN);
    else                       sat_c = OUT_W'(wide_c);
  end

  // Frame counter, fetch/sum/advance sequencer and per-channel trigger handling
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= CNT_RELOAD;
      slot        <= '0;
      lat_act     <= '0;
      issued      <= '0;
      skip        <= '0;
      data_vld    <= 1'b0;
      data_slot   <= '0;
      acc         <= '0;
      sound       <= '0;
      sound_valid <= 1'b0;
      active      <= '0;
      rom_addr    <= '0;
      rom_rd      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) pos[c] <= '0;
    end else begin
      sound_valid <= 1'b0;

      if (start_c)     cnt <= CNT_RELOAD;
      else if (enable) cnt <= cnt - CNT_W'(1);

      // Data for a slot returns one cycle after issue; track which slot it is
      data_vld  <= (state == FETCH);
      data_slot <= slot;
      if (data_vld) acc <= sum_c;

      if (|issue_c) begin
        rom_addr             <= ADDR_W'({issue_idx_c, pos[issue_idx_c]});
        rom_rd               <= active[issue_idx_c];
        lat_act[issue_idx_c] <= active[issue_idx_c];
      end

      case (state)
        IDLE: begin
          if (start_c) begin
            state <= FETCH;
            slot  <= '0;
            acc   <= '0;
          end
        end
        FETCH: begin
          if (slot == LAST_SLOT) begin
            state  <= SUM;
            rom_rd <= 1'b0;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
        SUM: begin
          sound       <= sat_c;
          sound_valid <= 1'b1;
          state       <= ADVANCE;
        end
        ADVANCE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (lat_act[c] && !skip[c]) begin
              if (pos[c] == LAST_POS) begin
                pos[c] <= '0;
                if (!loop[c]) active[c] <= 1'b0;
              end else begin
                pos[c] <= pos[c] + LOCAL_W'(1);
              end
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A trigger after a channel's slot was issued leaves that channel untouched by ADVANCE
      for (int c = 0; c < CHANNELS; c++) begin
        if (state == ADVANCE) begin
          issued[c] <= 1'b0;
          skip[c]   <= 1'b0;
        end else begin
          issued[c] <= issued[c] | issue_c[c];
          if (trig[c] && (issued[c] || issue_c[c])) skip[c] <= 1'b1;
        end
        if (trig[c]) begin
          active[c] <= 1'b1;
          pos[c]    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_drum_mixer.sv
// tb_drum_mixer: vector table plus scoreboard for the drum mixer, with a second
// instance at higher gain for the saturation corners.
module tb_drum_mixer;

  logic              CLOCK_50;
  logic              resetn;
  logic              enable;
  logic [1:0]        trig, loop;
  logic [2:0]        rom_addr;
  logic              rom_rd;
  logic signed [7:0] rom_q;
  logic signed [8:0] sound;
  logic              sound_valid;
  logic [1:0]        active;

  logic [1:0]        trig2, loop2;
  logic [2:0]        rom_addr2;
  logic              rom_rd2;
  logic signed [7:0] rom_q2;
  logic signed [8:0] sound2;
  logic              sound_valid2;
  logic [1:0]        active2;
  logic signed [7:0] sat_val;

  logic signed [7:0] rom_img [8];

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];

  drum_mixer #(.CHANNELS(2), .DATA_W(8), .LOCAL_W(2), .SAMPLE_LEN(4), .DIV(8),
               .GAIN_SHIFT(0), .OUT_W(9)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .trig(trig), .loop(loop),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q), .sound(sound),
    .sound_valid(sound_valid), .active(active));

  drum_mixer #(.CHANNELS(2), .DATA_W(8), .LOCAL_W(2), .SAMPLE_LEN(4), .DIV(8),
               .GAIN_SHIFT(1), .OUT_W(9)) dut_sat (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .trig(trig2), .loop(loop2),
    .rom_addr(rom_addr2), .rom_rd(rom_rd2), .rom_q(rom_q2), .sound(sound2),
    .sound_valid(sound_valid2), .active(active2));

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Synchronous ROMs; unread cycles return junk so ungated data shows up
  always @(posedge CLOCK_50) begin
    rom_q  <= rom_rd  ? rom_img[rom_addr] : 8'sh55;
    rom_q2 <= rom_rd2 ? sat_val           : 8'sh55;
  end

  typedef struct packed {
    logic [1:0]      trig;
    logic [1:0]      loop;
    logic [3:0]      n;
    logic [8:0][8:0] exp;
    logic [1:0]      act;
  } vec_t;

  vec_t vecs [4];

  function automatic vec_t mk(input logic [1:0] t, input logic [1:0] l, input int n,
                              input int e0, input int e1, input int e2, input int e3,
                              input int e4, input int e5, input int e6, input int e7,
                              input int e8, input logic [1:0] a);
    vec_t v;
    v.trig = t; v.loop = l; v.n = 4'(n); v.act = a;
    v.exp[0] = 9'(e0); v.exp[1] = 9'(e1); v.exp[2] = 9'(e2);
    v.exp[3] = 9'(e3); v.exp[4] = 9'(e4); v.exp[5] = 9'(e5);
    v.exp[6] = 9'(e6); v.exp[7] = 9'(e7); v.exp[8] = 9'(e8);
    return v;
  endfunction

  task automatic check(input string nm, input int act_v, input int exp_v);
    n_total++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (sound_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sound", int'(sound), e);
      end
    end
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLOCK_50);
      if (sound_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge CLOCK_50);
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic pulse(input logic [1:0] t);
    trig = t;
    @(negedge CLOCK_50);
    trig = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn = 1'b0; enable = 1'b1; trig = 2'b00; trig2 = 2'b00;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  initial begin
    int  n;
    bit  seen;
    vec_t v;

    rom_img = '{8'sd10, 8'sd20, 8'sd30, 8'sd40, -8'sd5, -8'sd5, -8'sd5, -8'sd5};
    resetn = 1'b0; enable = 1'b1; trig = 2'b00; loop = 2'b00;
    trig2 = 2'b00; loop2 = 2'b00; sat_val = 8'sd0;

    vecs[0] = mk(2'b01, 2'b00, 6, 10, 20, 30, 40, 0, 0, 0, 0, 0, 2'b00);
    vecs[1] = mk(2'b11, 2'b01, 9, 5, 15, 25, 35, 10, 20, 30, 40, 10, 2'b01);
    vecs[2] = mk(2'b10, 2'b10, 5, -5, -5, -5, -5, -5, 0, 0, 0, 0, 2'b10);
    vecs[3] = mk(2'b11, 2'b11, 5, 5, 15, 25, 35, 5, 0, 0, 0, 0, 2'b11);

    fork
      monitor();
    join_none

    // Reset values and first-frame latency
    repeat (3) @(negedge CLOCK_50);
    check("rst_sound", int'(sound), 0);
    check("rst_valid", int'(sound_valid), 0);
    check("rst_active", int'(active), 0);
    check("rst_rom_rd", int'(rom_rd), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    resetn = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLOCK_50);
      n++;
      @(negedge CLOCK_50);
      if (sound_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("first_valid_seen", int'(seen), 1);
    check("first_valid_latency", n, 11);
    check("first_sound", int'(sound), 0);

    // Table-driven playback patterns
    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      do_reset();
      wait_valid();
      loop = v.loop;
      for (int i = 0; i < int'(v.n); i++) exp_q.push_back(int'($signed(v.exp[i])));
      pulse(v.trig);
      drain();
      repeat (2) @(negedge CLOCK_50);
      check("vec_active", int'(active), int'(v.act));
    end

    // One-shot: active drops exactly at the ADVANCE of the 4th frame
    do_reset();
    wait_valid();
    loop = 2'b00;
    pulse(2'b01);
    repeat (4) wait_valid();
    check("oneshot_active_f4", int'(active), 1);
    @(negedge CLOCK_50);
    check("oneshot_active_adv", int'(active), 0);

    // Retrigger in the ADVANCE cycle of frame 2 restarts at sample 0
    do_reset();
    wait_valid();
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(10); exp_q.push_back(20);
    pulse(2'b01);
    repeat (2) wait_valid();
    pulse(2'b01);
    drain();

    // Trigger right after channel 0's slot: frame keeps 30, next frame restarts
    do_reset();
    wait_valid();
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30);
    exp_q.push_back(10); exp_q.push_back(20);
    pulse(2'b01);
    repeat (2) wait_valid();
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLOCK_50);
      if (rom_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("late_slot_addr", int'(rom_addr), 2);
    pulse(2'b01);
    drain();

    // Holding trig keeps the channel on sample 0
    do_reset();
    wait_valid();
    exp_q.push_back(10); exp_q.push_back(10); exp_q.push_back(10);
    trig = 2'b01;
    repeat (3) wait_valid();
    trig = 2'b00;
    drain();

    // Pause after frame 1: no output while disabled, resumes with 20
    do_reset();
    wait_valid();
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30);
    pulse(2'b01);
    wait_valid();
    enable = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (sound_valid) seen = 1'b1;
    end
    check("pause_no_valid", int'(seen), 0);
    enable = 1'b1;
    drain();

    // Saturation on the higher-gain instance
    do_reset();
    wait_valid();
    loop2 = 2'b11;
    sat_val = 8'sd127;
    trig2 = 2'b11;
    @(negedge CLOCK_50);
    trig2 = 2'b00;
    wait_valid();
    check("sat_valid", int'(sound_valid2), 1);
    check("sat_pos", int'(sound2), 255);
    sat_val = -8'sd128;
    wait_valid();
    check("sat_neg", int'(sound2), -256);
    sat_val = 8'sd50;
    wait_valid();
    check("gain_pos", int'(sound2), 200);
    sat_val = -8'sd60;
    wait_valid();
    check("gain_neg", int'(sound2), -240);

    // Reset during FETCH cycle 1 aborts the frame
    do_reset();
    wait_valid();
    loop = 2'b01;
    pulse(2'b01);
    wait_valid();
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLOCK_50);
      if (rom_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrst_found_fetch", int'(seen), 1);
    @(negedge CLOCK_50);
    check("midrst_slot1_addr", int'(rom_addr[2]), 1);
    resetn = 1'b0;
    @(posedge CLOCK_50);
    #1;
    check("midrst_sound", int'(sound), 0);
    check("midrst_valid", int'(sound_valid), 0);
    check("midrst_active", int'(active), 0);
    check("midrst_rom_rd", int'(rom_rd), 0);
    check("midrst_rom_addr", int'(rom_addr), 0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLOCK_50);
      if (sound_valid) seen = 1'b1;
    end
    check("midrst_no_valid", int'(seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
